// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and compare result codes for the ALU pipe.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_NOP  = 4'h8;
  localparam logic [3:0] OP_EQ   = 4'h9;
  localparam logic [3:0] OP_GT   = 4'hA;
  localparam logic [3:0] OP_LT   = 4'hB;
  localparam logic [3:0] OP_SHR  = 4'hC;
  localparam logic [3:0] OP_SHL  = 4'hD;
  localparam logic [3:0] OP_SRA  = 4'hE;
  localparam logic [3:0] OP_ROR  = 4'hF;

  localparam logic [1:0] CMP_NONE = 2'd0;
  localparam logic [1:0] CMP_EQ   = 2'd1;
  localparam logic [1:0] CMP_GT   = 2'd2;
  localparam logic [1:0] CMP_LT   = 2'd3;

  // Unit tag order: {arith, logic, cmp, shift}
  localparam logic [3:0] UNIT_ARITH = 4'b1000;
  localparam logic [3:0] UNIT_LOGIC = 4'b0100;
  localparam logic [3:0] UNIT_CMP   = 4'b0010;
  localparam logic [3:0] UNIT_SHIFT = 4'b0001;

  typedef enum logic {IDLE, DIV} state_e;

endpackage

// File: rtl/alu_div_seq.sv
// Iterative signed restoring divider: one quotient bit per cycle on magnitudes,
// sign applied combinationally on the final iteration.
module alu_div_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] quotient
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             busy_q;
  logic             neg_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] q_q;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   q_nx;
  logic [2*WIDTH-1:0] mag;

  always_comb begin
    abs_a   = A[WIDTH-1] ? ('0 - A) : A;
    abs_b   = B[WIDTH-1] ? ('0 - B) : B;
    shifted = {rem_q, q_q[WIDTH-1]};
    ge      = (shifted >= {1'b0, dvsr_q});
    // Remainder stays below the divisor, so the low WIDTH bits of the difference suffice
    rem_nx  = ge ? (shifted[WIDTH-1:0] - dvsr_q) : shifted[WIDTH-1:0];
    q_nx    = {q_q[WIDTH-2:0], ge};
    mag     = {{WIDTH{1'b0}}, q_nx};
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign quotient = neg_q ? ('0 - mag) : mag;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_q <= 1'b0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
      dvsr_q <= '0;
      rem_q  <= '0;
      q_q    <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      neg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
      cnt_q  <= '0;
      dvsr_q <= abs_b;
      rem_q  <= '0;
      q_q    <= abs_a;
    end else if (busy_q) begin
      rem_q <= rem_nx;
      q_q   <= q_nx;
      cnt_q <= cnt_q + CW'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked single-issue ALU: combinational units feed one registered result bus;
// divide runs on the iterative divider while the FSM sits in DIV.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         ALU_FUN,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res_out,
  output logic               arith_flag,
  output logic               logic_flag,
  output logic               cmp_flag,
  output logic               shift_flag,
  output logic               carry_out,
  output logic               overflow,
  output logic               div_by_zero,
  output logic               busy
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned RW  = 2 * WIDTH;
  localparam int unsigned M   = WIDTH - 1;
  localparam logic [SHW:0] W_AMT = (SHW + 1)'(WIDTH);

  state_e          state_q;
  logic            out_valid_q;
  logic [RW-1:0]   res_q;
  logic [3:0]      unit_q;
  logic            carry_q;
  logic            ovf_q;
  logic            dbz_q;

  logic [RW-1:0]   res_d;
  logic [3:0]      unit_d;
  logic            carry_d;
  logic            ovf_d;
  logic            dbz_d;

  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [RW-1:0]    a_ext;
  logic [RW-1:0]    b_ext;
  logic [RW-1:0]    prod;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] sra_w;
  logic [WIDTH-1:0] ror_w;

  logic            accept;
  logic            div_start;
  logic            div_busy;
  logic            div_done;
  logic [RW-1:0]   div_quot;

  assign in_ready  = RST && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign div_start = accept && (ALU_FUN == OP_DIV) && (B != '0);

  assign sh    = B[SHW-1:0];
  assign add_s = {A[M], A} + {B[M], B};
  assign sub_s = {A[M], A} - {B[M], B};
  assign a_ext = {{WIDTH{A[M]}}, A};
  assign b_ext = {{WIDTH{B[M]}}, B};
  assign prod  = a_ext * b_ext;
  assign sra_w = $signed(A) >>> sh;
  // Shifting by the full width yields 0, so a zero rotate amount returns A unchanged
  assign ror_w = (A >> sh) | (A << (W_AMT - {1'b0, sh}));

  always_comb begin
    res_d   = '0;
    unit_d  = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    dbz_d   = 1'b0;
    case (ALU_FUN)
      OP_ADD: begin
        unit_d  = UNIT_ARITH;
        res_d   = {{(WIDTH-1){add_s[WIDTH]}}, add_s};
        carry_d = (A[M] & B[M]) | ((A[M] | B[M]) & ~add_s[M]);
        ovf_d   = add_s[WIDTH] ^ add_s[M];
      end
      OP_SUB: begin
        unit_d  = UNIT_ARITH;
        res_d   = {{(WIDTH-1){sub_s[WIDTH]}}, sub_s};
        carry_d = (~A[M] & B[M]) | ((~A[M] | B[M]) & sub_s[M]);
        ovf_d   = sub_s[WIDTH] ^ sub_s[M];
      end
      OP_MUL: begin
        unit_d = UNIT_ARITH;
        res_d  = prod;
      end
      OP_DIV: begin
        unit_d = UNIT_ARITH;
        dbz_d  = (B == '0);
      end
      OP_AND:  begin unit_d = UNIT_LOGIC; res_d = {{WIDTH{1'b0}}, A & B};    end
      OP_OR:   begin unit_d = UNIT_LOGIC; res_d = {{WIDTH{1'b0}}, A | B};    end
      OP_NAND: begin unit_d = UNIT_LOGIC; res_d = {{WIDTH{1'b0}}, ~(A & B)}; end
      OP_NOR:  begin unit_d = UNIT_LOGIC; res_d = {{WIDTH{1'b0}}, ~(A | B)}; end
      OP_NOP:  begin unit_d = UNIT_CMP;   res_d = RW'(CMP_NONE); end
      OP_EQ: begin
        unit_d = UNIT_CMP;
        res_d  = (A == B) ? RW'(CMP_EQ) : '0;
      end
      OP_GT: begin
        unit_d = UNIT_CMP;
        res_d  = ($signed(A) > $signed(B)) ? RW'(CMP_GT) : '0;
      end
      OP_LT: begin
        unit_d = UNIT_CMP;
        res_d  = ($signed(A) < $signed(B)) ? RW'(CMP_LT) : '0;
      end
      OP_SHR:  begin unit_d = UNIT_SHIFT; res_d = {{WIDTH{1'b0}}, A >> sh}; end
      OP_SHL:  begin unit_d = UNIT_SHIFT; res_d = {{WIDTH{1'b0}}, A << sh}; end
      OP_SRA:  begin unit_d = UNIT_SHIFT; res_d = {{WIDTH{1'b0}}, sra_w};   end
      OP_ROR:  begin unit_d = UNIT_SHIFT; res_d = {{WIDTH{1'b0}}, ror_w};   end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      unit_q      <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_start) begin
            state_q     <= DIV;
            out_valid_q <= 1'b0;
          end else if (accept) begin
            out_valid_q <= 1'b1;
            res_q       <= res_d;
            unit_q      <= unit_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        DIV: begin
          if (div_done) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b1;
            res_q       <= div_quot;
            unit_q      <= UNIT_ARITH;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
          end
        end
      endcase
    end
  end

  alu_div_seq #(.WIDTH(WIDTH)) u_div (
    .CLK      (CLK),
    .RST      (RST),
    .start    (div_start),
    .A        (A),
    .B        (B),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  assign out_valid   = out_valid_q;
  assign res_out     = res_q;
  assign arith_flag  = unit_q[3];
  assign logic_flag  = unit_q[2];
  assign cmp_flag    = unit_q[1];
  assign shift_flag  = unit_q[0];
  assign carry_out   = carry_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;
  assign busy        = div_busy;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=16.
module tb_alu_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  ALU_FUN;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res_out;
  logic        arith_flag, logic_flag, cmp_flag, shift_flag;
  logic        carry_out, overflow, div_by_zero, busy;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  logic [67:0] vecs [14];

  alu_pipe #(.WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_FUN(ALU_FUN), .out_valid(out_valid), .out_ready(out_ready),
    .res_out(res_out), .arith_flag(arith_flag), .logic_flag(logic_flag),
    .cmp_flag(cmp_flag), .shift_flag(shift_flag), .carry_out(carry_out),
    .overflow(overflow), .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] fl;
    RST = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; ALU_FUN = '0;
    #2;
    fl = {arith_flag, logic_flag, cmp_flag, shift_flag, carry_out, overflow, div_by_zero};
    total_cnt++;
    if ({in_ready, out_valid, busy} !== 3'b000) $display("FAIL rst_ctrl: got %b expected 000", {in_ready, out_valid, busy});
    else pass_cnt++;
    total_cnt++;
    if (res_out !== 32'h0) $display("FAIL rst_res: got %h expected 00000000", res_out);
    else pass_cnt++;
    total_cnt++;
    if (fl !== 7'h0) $display("FAIL rst_flags: got %b expected 0000000", fl);
    else pass_cnt++;
    repeat (3) tick();
    RST = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_add();
    A = 16'd8; B = 16'd4; ALU_FUN = 4'h0; in_valid = 1'b1;
    tick();
    total_cnt++;
    if ({out_valid, res_out} !== {1'b1, 32'h0000000C}) $display("FAIL add_res: got %b/%h expected 1/0000000C", out_valid, res_out);
    else pass_cnt++;
    total_cnt++;
    if ({arith_flag, logic_flag, cmp_flag, shift_flag, carry_out, overflow} !== 6'b100000)
      $display("FAIL add_flags: got %b expected 100000", {arith_flag, logic_flag, cmp_flag, shift_flag, carry_out, overflow});
    else pass_cnt++;
    A = 16'h7FFF; B = 16'h0001;
    tick();
    total_cnt++;
    if ({res_out, overflow, carry_out} !== {32'h00008000, 2'b10}) $display("FAIL add_ovf: got %h/%b%b expected 00008000/10", res_out, overflow, carry_out);
    else pass_cnt++;
    A = 16'hFFFF; B = 16'h0001;
    tick();
    total_cnt++;
    if ({res_out, overflow, carry_out} !== {32'h00000000, 2'b01}) $display("FAIL add_carry: got %h/%b%b expected 00000000/01", res_out, overflow, carry_out);
    else pass_cnt++;
    A = 16'h0000; B = 16'h0001; ALU_FUN = 4'h1;
    tick();
    total_cnt++;
    if ({res_out, overflow, carry_out} !== {32'hFFFFFFFF, 2'b01}) $display("FAIL sub_borrow: got %h/%b%b expected FFFFFFFF/01", res_out, overflow, carry_out);
    else pass_cnt++;
    A = 16'h8000; B = 16'h0001;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if ({res_out, overflow, carry_out} !== {32'hFFFF7FFF, 2'b10}) $display("FAIL sub_ovf: got %h/%b%b expected FFFF7FFF/10", res_out, overflow, carry_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL add_drain: got %b expected 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_div();
    A = 16'hFFF8; B = 16'd4; ALU_FUN = 4'h3; in_valid = 1'b1;
    tick();
    A = 16'd1; B = 16'd1; ALU_FUN = 4'h0;
    for (int i = 0; i < 16; i++) begin
      total_cnt++;
      if ({busy, in_ready, out_valid} !== 3'b100) $display("FAIL div_busy_%0d: got %b expected 100", i, {busy, in_ready, out_valid});
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if ({out_valid, busy, arith_flag, res_out} !== {3'b101, 32'hFFFFFFFE}) $display("FAIL div_res: got %b/%h expected 101/FFFFFFFE", {out_valid, busy, arith_flag}, res_out);
    else pass_cnt++;
    in_valid = 1'b0;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL div_held_req_ignored: got %b expected 0", out_valid);
    else pass_cnt++;
    A = 16'h8000; B = 16'hFFFF; ALU_FUN = 4'h3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (16) tick();
    total_cnt++;
    if ({out_valid, res_out} !== {1'b1, 32'h00008000}) $display("FAIL div_min_neg1: got %b/%h expected 1/00008000", out_valid, res_out);
    else pass_cnt++;
    A = 16'd7; B = 16'hFFFE; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (16) tick();
    total_cnt++;
    if ({out_valid, res_out} !== {1'b1, 32'hFFFFFFFD}) $display("FAIL div_trunc: got %b/%h expected 1/FFFFFFFD", out_valid, res_out);
    else pass_cnt++;
  endtask

  task automatic test_div_zero();
    A = 16'd7; B = 16'd0; ALU_FUN = 4'h3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, busy, div_by_zero, arith_flag, res_out} !== {4'b1011, 32'h0})
      $display("FAIL div_zero: got %b/%h expected 1011/00000000", {out_valid, busy, div_by_zero, arith_flag}, res_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, in_ready} !== 2'b01) $display("FAIL div_zero_idle: got %b expected 01", {busy, in_ready});
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    A = 16'd8; B = 16'd4; ALU_FUN = 4'h4; in_valid = 1'b1;
    tick();
    ALU_FUN = 4'h5;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({out_valid, in_ready, logic_flag, res_out} !== {3'b101, 32'h0})
        $display("FAIL bp_hold_%0d: got %b/%h expected 101/00000000", i, {out_valid, in_ready, logic_flag}, res_out);
      else pass_cnt++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, logic_flag, res_out} !== {2'b11, 32'h0000000C}) $display("FAIL bp_next: got %b/%h expected 11/0000000C", {out_valid, logic_flag}, res_out);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op;
    logic [31:0] exp_res;
    logic [3:0]  exp_unit;
    vecs = '{
      {16'h8001, 16'h0004, 4'hC, 32'h00000800},
      {16'h8001, 16'h0004, 4'hD, 32'h00000010},
      {16'h8001, 16'h0004, 4'hE, 32'h0000F800},
      {16'h8001, 16'h0004, 4'hF, 32'h00001800},
      {16'h8001, 16'h0000, 4'hF, 32'h00008001},
      {16'h8001, 16'h0014, 4'hC, 32'h00000800},
      {16'h00F0, 16'h0F0F, 4'h6, 32'h0000FFFF},
      {16'h00F0, 16'h0F0F, 4'h7, 32'h0000F000},
      {16'h0005, 16'h0005, 4'h9, 32'h00000001},
      {16'hFFFF, 16'h0001, 4'hB, 32'h00000003},
      {16'hFFFF, 16'h0001, 4'hA, 32'h00000000},
      {16'h0003, 16'hFFFE, 4'hA, 32'h00000002},
      {16'h1234, 16'h5678, 4'h8, 32'h00000000},
      {16'hFFFD, 16'h0100, 4'h2, 32'hFFFFFD00}
    };
    in_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      A = vecs[i][67:52]; B = vecs[i][51:36]; op = vecs[i][35:32];
      ALU_FUN = op;
      exp_res = vecs[i][31:0];
      exp_unit = 4'b1000 >> op[3:2];
      tick();
      total_cnt++;
      if ({out_valid, res_out} !== {1'b1, exp_res}) $display("FAIL b2b_res_%0d: got %b/%h expected 1/%h", i, out_valid, res_out, exp_res);
      else pass_cnt++;
      total_cnt++;
      if ({arith_flag, logic_flag, cmp_flag, shift_flag, carry_out, overflow, div_by_zero} !== {exp_unit, 3'b000})
        $display("FAIL b2b_flags_%0d: got %b expected %b", i, {arith_flag, logic_flag, cmp_flag, shift_flag, carry_out, overflow, div_by_zero}, {exp_unit, 3'b000});
      else pass_cnt++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_div();
    int unsigned stray;
    A = 16'd8; B = 16'd4; ALU_FUN = 4'h3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    RST = 1'b0;
    #1;
    total_cnt++;
    if ({in_ready, out_valid, busy, res_out} !== {3'b000, 32'h0}) $display("FAIL mid_rst: got %b/%h expected 000/00000000", {in_ready, out_valid, busy}, res_out);
    else pass_cnt++;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    total_cnt++;
    if ({in_ready, busy, out_valid} !== 3'b100) $display("FAIL mid_rst_release: got %b expected 100", {in_ready, busy, out_valid});
    else pass_cnt++;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    total_cnt++;
    if (stray != 0) $display("FAIL mid_rst_stale: got %0d stray cycles expected 0", stray);
    else pass_cnt++;
    A = 16'd8; B = 16'd4; ALU_FUN = 4'hA; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, cmp_flag, res_out} !== {2'b11, 32'h00000002}) $display("FAIL mid_rst_cmp: got %b/%h expected 11/00000002", {out_valid, cmp_flag}, res_out);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_div();
    test_div_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
